axi_lite_native_responder: RTL and testbench
============================================

Name: axi_lite_native_responder

Overview:
- AXI4-Lite slave that terminates a CPU- or interconnect-side AXI-Lite master and drives a single native synchronous-SRAM-style port (ena/wen/addr/wdata/rdata).
- Sits at the memory end of the CPU's AXI master path, in front of block RAM or a native peripheral.
- Translates each AXI-Lite transaction into one native access; the native port has a fixed 1-cycle read latency.
- Buffers read data so that response-channel stalls never lose data.

Parameters:
- BASE, 32'h00000000, byte base address of the window; the native address is the AXI address minus BASE.
- LEN, 32'h00010000, window length in bytes; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- s_axi_awaddr  in  32  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  32  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- ena  out  1  native access enable
- wen  out  4  native byte write enables; 0 means read
- addr  out  32  native address (AXI address minus BASE)
- wdata  out  32  native write data
- rdata  in  32  native read data, valid the cycle after a read access

Behaviour:
- Reset state:
  - All outputs 0; rdata_buf = 0.
  - Read FSM in R_IDLE; bvalid = 0.
  - Reset mid-transaction discards any pending B or R response.
- Write acceptance:
  - accept_w = awvalid && wvalid && (!bvalid || bready).
  - awready = wready = accept_w (combinational, same cycle).
  - A lone awvalid or lone wvalid is never accepted.
- Read acceptance:
  - accept_r = arvalid && !accept_w && (state==R_IDLE || rvalid&&rready).
  - arready = accept_r.
- Native port:
  - On accept_w: ena=1, wen=wstrb, addr=awaddr-BASE, wdata=s_axi_wdata.
  - On accept_r: ena=1, wen=0, addr=araddr-BASE.
  - Otherwise ena=0, wen=0, addr=0; wdata always follows s_axi_wdata.
  - At most one native access per cycle.
- Write response:
  - bvalid rises the cycle after accept_w, bresp=2'b00.
  - bvalid holds until bready. If a new write is accepted while bready=1, bvalid stays 1.
  - wstrb=0 is still accepted (ena=1, wen=0) and returns OKAY.
- Read FSM:
  - R_IDLE: on accept_r go to R_BYPASS.
  - R_BYPASS: rvalid=1, s_axi_rdata=rdata (native). Capture rdata into rdata_buf every cycle.
    - rready && accept_r: stay in R_BYPASS.
    - rready && !accept_r: go to R_IDLE.
    - !rready: go to R_HOLD.
  - R_HOLD: rvalid=1, s_axi_rdata=rdata_buf.
    - rready && accept_r: go to R_BYPASS.
    - rready && !accept_r: go to R_IDLE.
    - Otherwise stay.
  - rresp=2'b00.
- Latency and throughput:
  - Read: AR handshake in cycle T, rvalid in T+1.
  - Write: AW/W handshake in cycle T, bvalid in T+1.
  - Full throughput of one transaction per cycle when bready/rready are held high.
- Simultaneous events:
  - Write wins the native port; the read waits one cycle.
  - A write issued while in R_HOLD does not disturb rdata_buf.
- Arithmetic: addr subtraction is modulo 2^32.

Optional Feature:
- Macro: AXI_LITE_RESPONDER_RANGE_CHECK_EN
- Defined:
  - An address with (addr-BASE) >= LEN is still handshaken normally but gets ena=0.
  - Out-of-range write: bresp=2'b10 (SLVERR).
  - Out-of-range read: rresp=2'b10, rdata=32'h00000000. rresp/rdata are registered with the FSM.
- Undefined: no range check; all addresses map and responses are always OKAY.

Test Plan:
- Write awaddr=BASE+0x10, wdata=32'hDEADBEEF, wstrb=4'hF, bready=1 -> same cycle ena=1, wen=4'hF, addr=0x10; next cycle bvalid=1, bresp=0; then read 0x10 -> rvalid at T+1, rdata=32'hDEADBEEF.
- Four back-to-back reads, arvalid and rready held 1 -> arready=1 every cycle, rvalid=1 for 4 consecutive cycles, each rdata matching its own address.
- Read 0x20 (data 32'h12345678) with rready low for 3 cycles while a write to 0x20 of 32'h0 is accepted -> rdata stays 32'h12345678 through R_HOLD; released on rready.
- awvalid, wvalid and arvalid asserted together -> cycle 0: awready=wready=1, arready=0; cycle 1: arready=1.
- bready=0 after one write, then a second write offered -> awready=0 until bready=1; no native access in between.
- With the macro defined, write and read at BASE+LEN -> ena=0, bresp=2'b10; rresp=2'b10, rdata=0.

Source files
------------

// File: rtl/axi_lite_native_responder.sv
// AXI4-Lite slave bridging to a native 1-cycle-latency SRAM-style port.
// Optional range check on [BASE, BASE+LEN): define AXI_LITE_RESPONDER_RANGE_CHECK_EN.
//
// state    | meaning
// R_IDLE   | no read response outstanding
// R_BYPASS | response valid, data taken straight from native rdata
// R_HOLD   | response stalled by rready, data served from rdata_buf
module axi_lite_native_responder #(
    parameter logic [31:0] BASE = 32'h00000000,
    parameter logic [31:0] LEN  = 32'h00010000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic        ena,
    output logic [3:0]  wen,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata
);

    typedef enum logic [1:0] {R_IDLE, R_BYPASS, R_HOLD} r_state_t;

    r_state_t    r_state;
    logic [31:0] rdata_buf;
    logic        r_oor_q;
    logic        accept_w;
    logic        accept_r;
    logic [31:0] w_off;
    logic [31:0] r_off;
    logic        w_oor;
    logic        r_oor;

    assign w_off = s_axi_awaddr - BASE;
    assign r_off = s_axi_araddr - BASE;

`ifdef AXI_LITE_RESPONDER_RANGE_CHECK_EN
    assign w_oor = (w_off >= LEN);
    assign r_oor = (r_off >= LEN);
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot};
`else
    assign w_oor = 1'b0;
    assign r_oor = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, LEN};
`endif

    assign s_axi_rvalid  = (r_state != R_IDLE);
    assign accept_w      = s_axi_awvalid && s_axi_wvalid && (!s_axi_bvalid || s_axi_bready);
    assign accept_r      = s_axi_arvalid && !accept_w &&
                           ((r_state == R_IDLE) || (s_axi_rvalid && s_axi_rready));
    assign s_axi_awready = accept_w;
    assign s_axi_wready  = accept_w;
    assign s_axi_arready = accept_r;
    assign wdata         = s_axi_wdata;

    // Write has priority on the single native port.
    always_comb begin
        ena  = 1'b0;
        wen  = 4'h0;
        addr = 32'h0;
        if (accept_w) begin
            ena  = !w_oor;
            wen  = w_oor ? 4'h0 : s_axi_wstrb;
            addr = w_off;
        end else if (accept_r) begin
            ena  = !r_oor;
            addr = r_off;
        end
    end

    always_comb begin
        s_axi_rdata = (r_state == R_HOLD) ? rdata_buf : rdata;
        s_axi_rresp = 2'b00;
        if (r_oor_q) begin
            s_axi_rdata = 32'h0;
            s_axi_rresp = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= R_IDLE;
            rdata_buf    <= 32'h0;
            r_oor_q      <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
        end else begin
            if (accept_w) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= w_oor ? 2'b10 : 2'b00;
            end else if (s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end

            if (accept_r)
                r_oor_q <= r_oor;

            case (r_state)
                R_IDLE: begin
                    if (accept_r)
                        r_state <= R_BYPASS;
                end
                R_BYPASS: begin
                    rdata_buf <= rdata;
                    if (!s_axi_rready)
                        r_state <= R_HOLD;
                    else if (!accept_r)
                        r_state <= R_IDLE;
                end
                R_HOLD: begin
                    if (s_axi_rready)
                        r_state <= accept_r ? R_BYPASS : R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_native_responder.sv
// Directed bench for axi_lite_native_responder: a transaction-level model
// (memory image, outstanding-response bookkeeping) checked every cycle, plus literal spot checks.
module tb_axi_lite_native_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] LEN  = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] awaddr = 0, wdata_in = 0, araddr = 0;
    logic [3:0]  wstrb = 0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata_axi;
    logic        ena;
    logic [3:0]  wen;
    logic [31:0] addr, wdata_n;
    logic [31:0] rdata_n = 0;

    int tests = 0;
    int failed = 0;

    axi_lite_native_responder #(.BASE(BASE), .LEN(LEN)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata_in), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata_axi), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .ena(ena), .wen(wen), .addr(addr), .wdata(wdata_n), .rdata(rdata_n)
    );

    always #5 clk = ~clk;

    // Native SRAM: registered read, byte-enabled write.
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (ena) begin
            if (wen == 4'h0)
                rdata_n <= sram[addr[9:2]];
            else
                for (int b = 0; b < 4; b++)
                    if (wen[b]) sram[addr[9:2]][b*8 +: 8] <= wdata_n[b*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference model.
    logic [31:0] mm [0:255];
    logic        bv_e = 0, rv_e = 0;
    logic [1:0]  br_e = 0, rr_e = 0;
    logic [31:0] rd_e = 0;

    function automatic logic out_of_range(input logic [31:0] off);
`ifdef AXI_LITE_RESPONDER_RANGE_CHECK_EN
        return off >= LEN;
`else
        return (off != off);
`endif
    endfunction

    always @(negedge clk) begin
        logic exp_aw, exp_ar, oor;
        logic [31:0] off;
        if (reset) begin
            bv_e = 0;
            rv_e = 0;
        end else begin
            exp_aw = awvalid && wvalid && (!bv_e || bready);
            exp_ar = arvalid && !exp_aw && (!rv_e || rready);
            chk("awready", awready, exp_aw);
            chk("wready", wready, exp_aw);
            chk("arready", arready, exp_ar);
            chk("wdata", wdata_n, wdata_in);
            chk("bvalid", bvalid, bv_e);
            if (bv_e) chk("bresp", bresp, br_e);
            chk("rvalid", rvalid, rv_e);
            if (rv_e) begin
                chk("rdata", rdata_axi, rd_e);
                chk("rresp", rresp, rr_e);
            end
            if (exp_aw || exp_ar) begin
                off = exp_aw ? awaddr - BASE : araddr - BASE;
                oor = out_of_range(off);
                chk("ena", ena, !oor);
                if (!oor) begin
                    chk("addr", addr, off);
                    chk("wen", wen, exp_aw ? wstrb : 4'h0);
                end
            end else begin
                chk("ena_idle", ena, 0);
                chk("wen_idle", wen, 0);
                chk("addr_idle", addr, 0);
            end
            // advance model to the next cycle
            if (rv_e && rready) rv_e = 0;
            if (exp_ar) begin
                off  = araddr - BASE;
                oor  = out_of_range(off);
                rv_e = 1;
                rd_e = oor ? 32'h0 : mm[off[9:2]];
                rr_e = oor ? 2'b10 : 2'b00;
            end
            if (exp_aw) begin
                off  = awaddr - BASE;
                oor  = out_of_range(off);
                bv_e = 1;
                br_e = oor ? 2'b10 : 2'b00;
                if (!oor)
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) mm[off[9:2]][b*8 +: 8] = wdata_in[b*8 +: 8];
            end else if (bready) begin
                bv_e = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        awvalid = v; wvalid = v; awaddr = a; wdata_in = d; wstrb = s;
    endtask

    int cnt_ar, cnt_rv;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram[i] = 32'h0;
            mm[i]   = 32'h0;
        end
        @(negedge clk);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_ena", ena, 0);
        chk("rst_rdata", rdata_axi, 0);
        step();
        reset = 0;
        bready = 1; rready = 1;

        // single write then read back
        set_w(1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        chk("t1_ena", ena, 1);
        chk("t1_wen", wen, 4'hF);
        chk("t1_addr", addr, 32'h10);
        step();
        set_w(0, 0, 0, 0);
        @(negedge clk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        step();
        arvalid = 1; araddr = BASE + 32'h10;
        @(negedge clk);
        chk("t1_arready", arready, 1);
        step();
        arvalid = 0;
        @(negedge clk);
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata_axi, 32'hDEADBEEF);
        step();

        // back-to-back writes (full and partial strobes), then four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            set_w(1, BASE + 32'h40 + 32'(i * 4), 32'hA0B0C0D0 + 32'(i), 4'hF);
            step();
        end
        set_w(1, BASE + 32'h40, 32'h11223344, 4'b0101);
        step();
        set_w(1, BASE + 32'h44, 32'hFFFFFFFF, 4'b0000);
        step();
        set_w(0, 0, 0, 0);
        step();
        cnt_ar = 0; cnt_rv = 0;
        for (int i = 0; i < 4; i++) begin
            arvalid = 1; araddr = BASE + 32'h40 + 32'(i * 4);
            @(negedge clk);
            if (arready) cnt_ar++;
            if (rvalid) cnt_rv++;
            step();
        end
        arvalid = 0;
        @(negedge clk);
        if (rvalid) cnt_rv++;
        chk("t2_rdata_last", rdata_axi, 32'hA0B0C0D3);
        chk("t2_arready_cnt", cnt_ar, 4);
        step();
        chk("t2_rvalid_cnt", cnt_rv, 4);

        // read stalled in hold while a write hits the same word
        set_w(1, BASE + 32'h20, 32'h12345678, 4'hF);
        step();
        set_w(0, 0, 0, 0);
        rready = 0;
        arvalid = 1; araddr = BASE + 32'h20;
        step();
        arvalid = 0;
        set_w(1, BASE + 32'h20, 32'h0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_hold_rdata", rdata_axi, 32'h12345678);
            step();
            set_w(0, 0, 0, 0);
        end
        rready = 1;
        @(negedge clk);
        chk("t3_release", rdata_axi, 32'h12345678);
        step();
        arvalid = 1; araddr = BASE + 32'h20;
        step();
        arvalid = 0;
        @(negedge clk);
        chk("t3_reread", rdata_axi, 32'h0);
        step();

        // simultaneous write and read: write first
        set_w(1, BASE + 32'h30, 32'hCAFEF00D, 4'hF);
        arvalid = 1; araddr = BASE + 32'h10;
        @(negedge clk);
        chk("t4_awready", awready, 1);
        chk("t4_arready0", arready, 0);
        step();
        set_w(0, 0, 0, 0);
        @(negedge clk);
        chk("t4_arready1", arready, 1);
        step();
        arvalid = 0;
        step();

        // write response backpressure
        bready = 0;
        set_w(1, BASE + 32'h50, 32'h55AA55AA, 4'hF);
        step();
        set_w(1, BASE + 32'h54, 32'h66666666, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_awready_blocked", awready, 0);
            chk("t5_ena_blocked", ena, 0);
            step();
        end
        bready = 1;
        @(negedge clk);
        chk("t5_awready_free", awready, 1);
        step();
        set_w(0, 0, 0, 0);
        step();
        arvalid = 1; araddr = BASE + 32'h54;
        step();
        arvalid = 0;
        @(negedge clk);
        chk("t5_readback", rdata_axi, 32'h66666666);
        step();

`ifdef AXI_LITE_RESPONDER_RANGE_CHECK_EN
        set_w(1, BASE + LEN, 32'h77777777, 4'hF);
        @(negedge clk);
        chk("t6_w_ena", ena, 0);
        step();
        set_w(0, 0, 0, 0);
        @(negedge clk);
        chk("t6_bresp", bresp, 2'b10);
        step();
        arvalid = 1; araddr = BASE + LEN;
        @(negedge clk);
        chk("t6_r_ena", ena, 0);
        step();
        arvalid = 0;
        @(negedge clk);
        chk("t6_rresp", rresp, 2'b10);
        chk("t6_rdata", rdata_axi, 32'h0);
        step();
`endif

        // reset with both responses pending
        bready = 0; rready = 0;
        set_w(1, BASE + 32'h60, 32'h1, 4'hF);
        step();
        set_w(0, 0, 0, 0);
        arvalid = 1; araddr = BASE + 32'h10;
        step();
        arvalid = 0;
        step();
        reset = 1;
        #1;
        chk("t7_rst_bvalid", bvalid, 0);
        chk("t7_rst_rvalid", rvalid, 0);
        step();
        reset = 0;
        bready = 1; rready = 1;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
